// File: rtl/l2_mp_array_pkg.sv
// Shared types and helpers for the L2 multi-port storage array.
package l2_mp_array_pkg;

  localparam int unsigned BYTE_W = 8;

  typedef enum logic {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } clr_state_t;

  // One byte of a masked update; shared by the write port and the read bypass.
  function automatic logic [BYTE_W-1:0] byte_merge(
    input logic [BYTE_W-1:0] old_b,
    input logic [BYTE_W-1:0] new_b,
    input logic              mask
  );
    return mask ? new_b : old_b;
  endfunction

endpackage

// File: rtl/l2_mp_array_if.sv
// Write/read bus of the L2 storage array; master drives requests, slave returns data.
interface l2_mp_array_if #(
  parameter int unsigned S_INDEX = 4,
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned NUM_RD  = 2
);
  localparam int unsigned NBYTES = WIDTH / 8;

  logic                               busy;
  logic [NUM_RD-1:0]                  read;
  logic [NUM_RD-1:0][S_INDEX-1:0]     rindex;
  logic [NUM_RD-1:0][WIDTH-1:0]       dataout;
  logic                               load;
  logic [S_INDEX-1:0]                 windex;
  logic [NBYTES-1:0]                  wmask;
  logic [WIDTH-1:0]                   datain;

  modport master (
    output read, rindex, load, windex, wmask, datain,
    input  busy, dataout
  );

  modport slave (
    input  read, rindex, load, windex, wmask, datain,
    output busy, dataout
  );
endinterface

// File: rtl/l2_mp_array_clear_seq.sv
// Post-reset clear sweep: zeroes one set per cycle and reports busy until done.
module l2_mp_array_clear_seq
  import l2_mp_array_pkg::*;
#(
  parameter int unsigned S_INDEX      = 4,
  parameter int unsigned CLEAR_ON_RST = 1
) (
  input  logic               clk,
  input  logic               rst,
  output logic               o_busy,
  output logic               o_clr_we_c,
  output logic [S_INDEX-1:0] o_clr_idx
);

  localparam int unsigned NUM_SETS = 1 << S_INDEX;
  localparam int unsigned CW       = S_INDEX + 1;

  generate
    if (CLEAR_ON_RST != 0) begin : g_seq
      clr_state_t    r_state;
      clr_state_t    w_state_nxt;
      logic [CW-1:0] r_clr_idx;
      logic [CW-1:0] w_clr_idx_nxt;
      logic          r_busy;

      always_ff @(posedge clk) begin
        if (rst) begin
          r_state   <= CLEAR;
          r_clr_idx <= '0;
          r_busy    <= 1'b1;
        end else begin
          r_state   <= w_state_nxt;
          r_clr_idx <= w_clr_idx_nxt;
          r_busy    <= (w_state_nxt == CLEAR);
        end
      end

      // The last set's write and the move to IDLE share one edge.
      always_comb begin
        w_state_nxt   = r_state;
        w_clr_idx_nxt = r_clr_idx;
        case (r_state)
          CLEAR: begin
            w_clr_idx_nxt = r_clr_idx + CW'(1);
            if (r_clr_idx == CW'(NUM_SETS - 1)) begin
              w_state_nxt = IDLE;
            end
          end
          IDLE: begin
            w_state_nxt = IDLE;
          end
        endcase
      end

      assign o_busy     = r_busy;
      assign o_clr_we_c = (r_state == CLEAR) & ~rst;
      assign o_clr_idx  = r_clr_idx[S_INDEX-1:0];
    end else begin : g_none
      assign o_busy     = 1'b0;
      assign o_clr_we_c = 1'b0;
      assign o_clr_idx  = '0;
    end
  endgenerate

endmodule

// File: rtl/l2_mp_array.sv
// L2 storage array: one byte-masked write port, NUM_RD read ports with per-byte bypass.
module l2_mp_array
  import l2_mp_array_pkg::*;
#(
  parameter int unsigned S_INDEX      = 4,
  parameter int unsigned WIDTH        = 32,
  parameter int unsigned NUM_RD       = 2,
  parameter int unsigned RD_REG       = 0,
  parameter int unsigned CLEAR_ON_RST = 1
) (
  input  logic          clk,
  input  logic          rst,
  l2_mp_array_if.slave  bus
);

  localparam int unsigned NUM_SETS = 1 << S_INDEX;
  localparam int unsigned NBYTES   = WIDTH / 8;

  logic               w_busy;
  logic               w_clr_we;
  logic [S_INDEX-1:0] w_clr_idx;
  logic               w_byp_en;
  logic               w_wr_en;

  (* ramstyle = "logic" *) logic [WIDTH-1:0] r_mem [NUM_SETS];

  l2_mp_array_clear_seq #(
    .S_INDEX      (S_INDEX),
    .CLEAR_ON_RST (CLEAR_ON_RST)
  ) u_clear_seq (
    .clk        (clk),
    .rst        (rst),
    .o_busy     (w_busy),
    .o_clr_we_c (w_clr_we),
    .o_clr_idx  (w_clr_idx)
  );

  assign bus.busy = w_busy;
  assign w_byp_en = bus.load & ~w_busy;
  assign w_wr_en  = w_byp_en & ~rst;

  // Storage: flop-reset clear, sweep clear, or masked write.
  always_ff @(posedge clk) begin
    if (rst && (CLEAR_ON_RST == 0)) begin
      for (int s = 0; s < int'(NUM_SETS); s++) begin
        r_mem[s] <= '0;
      end
    end else if (w_clr_we) begin
      r_mem[w_clr_idx] <= '0;
    end else if (w_wr_en) begin
      for (int b = 0; b < int'(NBYTES); b++) begin
        r_mem[bus.windex][BYTE_W*b +: BYTE_W] <= byte_merge(
          r_mem[bus.windex][BYTE_W*b +: BYTE_W],
          bus.datain[BYTE_W*b +: BYTE_W],
          bus.wmask[b]);
      end
    end
  end

  generate
    for (genvar gi = 0; gi < int'(NUM_RD); gi++) begin : g_rd
      logic             w_hit;
      logic [WIDTH-1:0] w_merge;

      assign w_hit = w_byp_en & (bus.windex == bus.rindex[gi]);

      always_comb begin
        w_merge = '0;
        for (int b = 0; b < int'(NBYTES); b++) begin
          w_merge[BYTE_W*b +: BYTE_W] = byte_merge(
            r_mem[bus.rindex[gi]][BYTE_W*b +: BYTE_W],
            bus.datain[BYTE_W*b +: BYTE_W],
            w_hit & bus.wmask[b]);
        end
      end

      if (RD_REG != 0) begin : g_reg
        logic [WIDTH-1:0] r_dout;

        always_ff @(posedge clk) begin
          if (rst) begin
            r_dout <= '0;
          end else if (bus.read[gi] && !w_busy) begin
            r_dout <= w_merge;
          end
        end

        assign bus.dataout[gi] = r_dout;
      end else begin : g_comb
        assign bus.dataout[gi] = w_busy ? '0 : w_merge;
      end
    end
  endgenerate

endmodule

// File: tb/tb_l2_mp_array.sv
// Randomized and directed checks of l2_mp_array in combinational and registered read modes.
module tb_l2_mp_array;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            b_rst;
  logic            b_load;
  logic [3:0]      b_windex;
  logic [3:0]      b_wmask;
  logic [31:0]     b_datain;
  logic [1:0]      b_read;
  logic [1:0][3:0] b_rindex;

  l2_mp_array_if #(.S_INDEX(4), .WIDTH(32), .NUM_RD(2)) if0 ();
  l2_mp_array_if #(.S_INDEX(4), .WIDTH(32), .NUM_RD(2)) if1 ();

  assign if0.read = b_read;   assign if1.read = b_read;
  assign if0.rindex = b_rindex; assign if1.rindex = b_rindex;
  assign if0.load = b_load;   assign if1.load = b_load;
  assign if0.windex = b_windex; assign if1.windex = b_windex;
  assign if0.wmask = b_wmask; assign if1.wmask = b_wmask;
  assign if0.datain = b_datain; assign if1.datain = b_datain;

  l2_mp_array #(.S_INDEX(4), .WIDTH(32), .NUM_RD(2), .RD_REG(0), .CLEAR_ON_RST(1))
    u_dut0 (.clk(clk), .rst(b_rst), .bus(if0));
  l2_mp_array #(.S_INDEX(4), .WIDTH(32), .NUM_RD(2), .RD_REG(1), .CLEAR_ON_RST(1))
    u_dut1 (.clk(clk), .rst(b_rst), .bus(if1));

  int n_vec = 0;
  int n_err = 0;

  // Reference state: array contents, cycles of clearing left, registered read data.
  logic [31:0] m_mem [16];
  logic [31:0] m_dout [2];
  int          m_left = 0;
  bit          m_valid = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] mdl_read(input logic [3:0] idx);
    logic [31:0] r;
    r = m_mem[idx];
    if (b_load && m_left == 0 && b_windex == idx) begin
      for (int b = 0; b < 4; b++) begin
        if (b_wmask[b]) r[8*b +: 8] = b_datain[8*b +: 8];
      end
    end
    return r;
  endfunction

  function automatic logic [31:0] mdl_comb(input int port);
    return (m_left > 0) ? 32'h0 : mdl_read(b_rindex[port]);
  endfunction

  task automatic mdl_edge();
    logic [31:0] rd [2];
    for (int i = 0; i < 2; i++) rd[i] = mdl_read(b_rindex[i]);
    if (b_rst) begin
      m_left  = 16;
      m_dout[0] = 32'h0;
      m_dout[1] = 32'h0;
      m_valid = 1'b1;
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0) begin
        for (int s = 0; s < 16; s++) m_mem[s] = 32'h0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (b_read[i]) m_dout[i] = rd[i];
      end
      if (b_load) begin
        for (int b = 0; b < 4; b++) begin
          if (b_wmask[b]) m_mem[b_windex][8*b +: 8] = b_datain[8*b +: 8];
        end
      end
    end
  endtask

  // One clock: check comb outputs before the edge, registered outputs after it.
  task automatic tick();
    #1;
    if (m_valid) begin
      chk("busy0", 32'(if0.busy), 32'(m_left > 0));
      chk("comb_p0", if0.dataout[0], mdl_comb(0));
      chk("comb_p1", if0.dataout[1], mdl_comb(1));
    end
    @(posedge clk);
    mdl_edge();
    #1;
    if (m_valid) begin
      chk("busy1", 32'(if1.busy), 32'(m_left > 0));
      chk("reg_p0", if1.dataout[0], m_dout[0]);
      chk("reg_p1", if1.dataout[1], m_dout[1]);
    end
  endtask

  initial begin
    int cnt;
    b_rst = 1'b1; b_load = 1'b0; b_windex = '0; b_wmask = '0;
    b_datain = '0; b_read = '0; b_rindex = '0;
    for (int s = 0; s < 16; s++) m_mem[s] = 32'h0;
    m_dout[0] = 32'h0; m_dout[1] = 32'h0;

    // Clear sweep with a dropped mid-sweep write to idx 5
    repeat (3) tick();
    b_rst = 1'b0;
    cnt = 0;
    while (if0.busy && cnt < 40) begin
      cnt++;
      if (cnt == 4) begin
        b_load = 1'b1; b_windex = 4'd5; b_wmask = 4'hf; b_datain = 32'hffffffff;
      end else begin
        b_load = 1'b0;
      end
      tick();
    end
    chk("busy_len", 32'(cnt), 32'd16);
    b_load = 1'b0;
    b_read = 2'b11;
    for (int i = 0; i < 16; i++) begin
      b_rindex[0] = 4'(i); b_rindex[1] = 4'(15 - i);
      #1;
      chk("clr_p0", if0.dataout[0], 32'h0);
      chk("clr_p1", if0.dataout[1], 32'h0);
      tick();
    end

    // Reset reasserted partway through the sweep
    b_rst = 1'b1; tick(); tick();
    b_rst = 1'b0;
    repeat (9) tick();
    b_rst = 1'b1; tick();
    b_rst = 1'b0;
    cnt = 0;
    while (if0.busy && cnt < 40) begin
      cnt++;
      tick();
    end
    chk("busy_len2", 32'(cnt), 32'd16);

    // Byte mask, then registered read and hold
    b_read = 2'b00;
    b_load = 1'b1; b_windex = 4'd3; b_wmask = 4'hf; b_datain = 32'hAABBCCDD;
    tick();
    b_wmask = 4'h5; b_datain = 32'h11223344;
    tick();
    b_load = 1'b0; b_rindex[0] = 4'd3; b_rindex[1] = 4'd0; b_read = 2'b01;
    #1;
    chk("mask_p0", if0.dataout[0], 32'hAA22CC44);
    tick();
    chk("rdreg_p0", if1.dataout[0], 32'hAA22CC44);
    b_read = 2'b00;
    b_load = 1'b1; b_windex = 4'd3; b_wmask = 4'hf; b_datain = 32'h0;
    tick();
    b_load = 1'b0;
    tick();
    chk("rdhold_p0", if1.dataout[0], 32'hAA22CC44);

    // Same-cycle bypass on port 0, untouched index on port 1
    b_load = 1'b1; b_windex = 4'd6; b_wmask = 4'hf; b_datain = 32'h66666666;
    tick();
    b_windex = 4'd7; b_wmask = 4'h3; b_datain = 32'hDEADBEEF;
    b_rindex[0] = 4'd7; b_rindex[1] = 4'd6;
    #1;
    chk("byp_p0", if0.dataout[0], 32'h0000BEEF);
    chk("byp_p1", if0.dataout[1], 32'h66666666);
    tick();

    // Both ports on the index being written
    b_windex = 4'd3; b_wmask = 4'hA; b_datain = 32'h12345678;
    b_rindex[0] = 4'd3; b_rindex[1] = 4'd3; b_read = 2'b11;
    #1;
    chk("conf_p0", if0.dataout[0], 32'h12005600);
    chk("conf_p1", if0.dataout[1], 32'h12005600);
    tick();
    chk("conf_r0", if1.dataout[0], 32'h12005600);
    chk("conf_r1", if1.dataout[1], 32'h12005600);

    // Random traffic with occasional resets
    for (int n = 0; n < 400; n++) begin
      b_rst    = ($urandom_range(0, 99) == 0);
      b_load   = 1'($urandom);
      b_windex = 4'($urandom);
      b_wmask  = 4'($urandom);
      b_datain = $urandom;
      b_read   = 2'($urandom);
      for (int i = 0; i < 2; i++) begin
        b_rindex[i] = ($urandom_range(0, 2) == 0) ? b_windex : 4'($urandom);
      end
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
